riscv_pipe_stage_reg: RTL and testbench

- Generic, parametrised inter-stage pipeline register for the pipelined RV32I core. Replaces the fixed per-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries a control bundle and a data bundle across a valid/ready handshake, so a stage can stall or be flushed.
- When empty, the output control bits are forced to a bubble pattern, so downstream write-enables never assert on a bubble.
- An optional skid buffer registers the upstream ready, cutting the combinational ready path.

---
 rtl/riscv_pipe_stage_reg.sv | 99 +++++++++
 tb/tb_riscv_pipe_stage_reg.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/riscv_pipe_stage_reg.sv
// rtl/riscv_pipe_stage_reg.sv - inter-stage pipeline register with valid/ready, flush and optional skid buffer
module riscv_pipe_stage_reg #(
    parameter int                CTRL_W      = 2,
    parameter int                DATA_W      = 69,
    parameter logic [CTRL_W-1:0] CTRL_BUBBLE = {CTRL_W{1'b0}},
    parameter int                SKID        = 0
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_flush,
    input  logic              i_up_valid,
    output logic              o_up_ready,
    input  logic [CTRL_W-1:0] i_up_ctrl,
    input  logic [DATA_W-1:0] i_up_data,
    output logic              o_dn_valid,
    input  logic              i_dn_ready,
    output logic [CTRL_W-1:0] o_dn_ctrl,
    output logic [DATA_W-1:0] o_dn_data,
    output logic [1:0]        o_count
);

    logic              main_valid_q, main_valid_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic              skid_valid_q, skid_valid_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic              up_ready_q;
    logic              up_xfer, dn_xfer;

    assign o_up_ready = (SKID != 0) ? up_ready_q : (!main_valid_q || i_dn_ready);
    assign up_xfer    = i_up_valid && o_up_ready;
    assign dn_xfer    = main_valid_q && i_dn_ready;

    assign o_dn_valid = main_valid_q;
    assign o_dn_ctrl  = main_valid_q ? main_ctrl_q : CTRL_BUBBLE;
    assign o_dn_data  = main_data_q;
    assign o_count    = {1'b0, main_valid_q} + {1'b0, skid_valid_q};

    always_comb begin
        main_valid_d = main_valid_q;
        main_ctrl_d  = main_ctrl_q;
        main_data_d  = main_data_q;
        skid_valid_d = skid_valid_q;
        skid_ctrl_d  = skid_ctrl_q;
        skid_data_d  = skid_data_q;
        if (i_flush) begin
            // Only the valid flags are killed; the bubble mask hides stale ctrl.
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (SKID == 0) begin
            if (up_xfer) begin
                main_valid_d = 1'b1;
                main_ctrl_d  = i_up_ctrl;
                main_data_d  = i_up_data;
            end else if (dn_xfer) begin
                main_valid_d = 1'b0;
            end
        end else begin
            if (dn_xfer && skid_valid_q) begin
                // Ready was low this cycle, so no upstream entry competes here.
                main_ctrl_d  = skid_ctrl_q;
                main_data_d  = skid_data_q;
                skid_valid_d = 1'b0;
            end else if (up_xfer && (!main_valid_q || dn_xfer)) begin
                main_valid_d = 1'b1;
                main_ctrl_d  = i_up_ctrl;
                main_data_d  = i_up_data;
            end else if (up_xfer) begin
                skid_valid_d = 1'b1;
                skid_ctrl_d  = i_up_ctrl;
                skid_data_d  = i_up_data;
            end else if (dn_xfer) begin
                main_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            main_valid_q <= 1'b0;
            main_ctrl_q  <= CTRL_BUBBLE;
            main_data_q  <= '0;
            skid_valid_q <= 1'b0;
            skid_ctrl_q  <= CTRL_BUBBLE;
            skid_data_q  <= '0;
            up_ready_q   <= 1'b1;
        end else begin
            main_valid_q <= main_valid_d;
            main_ctrl_q  <= main_ctrl_d;
            main_data_q  <= main_data_d;
            skid_valid_q <= skid_valid_d;
            skid_ctrl_q  <= skid_ctrl_d;
            skid_data_q  <= skid_data_d;
            up_ready_q   <= !skid_valid_d;
        end
    end

endmodule

// File: tb/tb_riscv_pipe_stage_reg.sv
// tb/tb_riscv_pipe_stage_reg.sv - scoreboard bench for riscv_pipe_stage_reg, SKID=0 and SKID=1
module tb_riscv_pipe_stage_reg;

    logic        clk = 1'b0;
    logic        rstn;
    logic        flush;
    logic        up_valid;
    logic [1:0]  up_ctrl;
    logic [68:0] up_data;
    logic        dn_ready;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    task automatic chk(input int sk, input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL skid%0d %s: got %0h expected %0h at %0t", sk, name, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : st
        localparam int         SK  = g;
        localparam logic [1:0] BUB = (g == 0) ? 2'b00 : 2'b10;

        logic        up_ready, dn_valid;
        logic [1:0]  dn_ctrl, count;
        logic [68:0] dn_data;

        // Reference: a FIFO of capacity 1+SK; entries are {ctrl, data}.
        logic [70:0] q[$];
        logic        acc = 1'b0;
        logic [70:0] ent;
        int          sz;
        logic        pr;

        riscv_pipe_stage_reg #(
            .CTRL_W(2), .DATA_W(69), .CTRL_BUBBLE(BUB), .SKID(SK)
        ) dut (
            .i_clk(clk), .i_rstn(rstn), .i_flush(flush),
            .i_up_valid(up_valid), .o_up_ready(up_ready),
            .i_up_ctrl(up_ctrl), .i_up_data(up_data),
            .o_dn_valid(dn_valid), .i_dn_ready(dn_ready),
            .o_dn_ctrl(dn_ctrl), .o_dn_data(dn_data), .o_count(count)
        );

        always @(negedge rstn) begin
            q.delete();
            acc = 1'b0;
        end

        // Monitor: compare outputs with the model, pop on downstream transfer.
        always @(negedge clk) begin
            if (rstn) begin
                sz = q.size();
                pr = (SK != 0) ? (sz < 2) : (sz == 0 || dn_ready);
                chk(SK, "up_ready", {127'd0, up_ready}, {127'd0, pr});
                chk(SK, "dn_valid", {127'd0, dn_valid}, {127'd0, sz != 0});
                chk(SK, "count", {126'd0, count}, 128'(sz));
                if (!dn_valid)
                    chk(SK, "bubble_ctrl", {126'd0, dn_ctrl}, {126'd0, BUB});
                if (sz != 0) begin
                    chk(SK, "dn_entry", {57'd0, dn_ctrl, dn_data}, {57'd0, q[0]});
                    if (dn_ready) void'(q.pop_front());
                end
                acc = up_valid && pr;
                ent = {up_ctrl, up_data};
            end else begin
                acc = 1'b0;
            end
        end

        // Model update at the edge: flush discards everything still held.
        always @(posedge clk) begin
            if (rstn) begin
                if (flush) q.delete();
                else if (acc) q.push_back(ent);
            end
        end
    end

    task automatic drive(input logic v, input logic [1:0] c, input logic [68:0] d,
                         input logic r, input logic f);
        @(posedge clk);
        #1;
        up_valid = v;
        up_ctrl  = c;
        up_data  = d;
        dn_ready = r;
        flush    = f;
    endtask

    logic [95:0] rnd;

    initial begin
        rstn = 1'b0; flush = 1'b0; up_valid = 1'b0; up_ctrl = '0; up_data = '0; dn_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        drive(0, 2'b00, 69'd0, 1, 0);

        drive(1, 2'b11, 69'h1_2345_6789_ABCD_EF01, 1, 0);
        drive(0, 2'b00, 69'd0, 1, 0);
        drive(0, 2'b00, 69'd0, 1, 0);

        for (int i = 1; i <= 8; i++) drive(1, 2'(i), 69'(i), 1, 0);
        drive(0, 2'b00, 69'd0, 1, 0);
        drive(0, 2'b00, 69'd0, 1, 0);

        drive(1, 2'b01, 69'd5, 1, 0);
        for (int i = 0; i < 3; i++) drive(1, 2'b10, 69'd6, 0, 0);
        drive(1, 2'b10, 69'd6, 1, 0);
        repeat (3) drive(0, 2'b00, 69'd0, 1, 0);

        drive(1, 2'b01, 69'hA, 0, 0);
        drive(1, 2'b10, 69'hB, 0, 0);
        drive(0, 2'b00, 69'd0, 0, 0);
        drive(1, 2'b11, 69'hC, 1, 0);
        repeat (4) drive(0, 2'b00, 69'd0, 1, 0);

        drive(1, 2'b01, 69'hA, 0, 0);
        drive(1, 2'b10, 69'hB, 0, 0);
        drive(1, 2'b11, 69'hC, 0, 1);
        drive(0, 2'b00, 69'd0, 0, 0);
        drive(0, 2'b00, 69'd0, 1, 0);

        for (int i = 0; i < 10000; i++) begin
            rnd = {$urandom, $urandom, $urandom};
            drive(($urandom % 4) != 0, 2'($urandom), rnd[68:0],
                  ($urandom % 3) != 0, ($urandom % 50) == 0);
            rstn = (i != 5000);
        end
        drive(0, 2'b00, 69'd0, 1, 0);
        repeat (3) drive(0, 2'b00, 69'd0, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
